// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display path.
package calc_pkg;
   typedef enum logic [1:0] {
      ST_ERRO    = 2'b00,
      ST_OCUPADO = 2'b01,
      ST_PRONTO  = 2'b10
   } status_t;

   localparam int NUM_DIGITS = 8;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_E     = 8'b1000_0110;
endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low {dp,g,f,e,d,c,b,a} pattern; dp always off.
module hex7seg (
   input  logic [3:0] val_i,
   output logic [7:0] seg_o
);
   always_comb begin
      case (val_i)
         4'h0:    seg_o = 8'hC0;
         4'h1:    seg_o = 8'hF9;
         4'h2:    seg_o = 8'hA4;
         4'h3:    seg_o = 8'hB0;
         4'h4:    seg_o = 8'h99;
         4'h5:    seg_o = 8'h92;
         4'h6:    seg_o = 8'h82;
         4'h7:    seg_o = 8'hF8;
         4'h8:    seg_o = 8'h80;
         4'h9:    seg_o = 8'h90;
         4'hA:    seg_o = 8'h88;
         4'hB:    seg_o = 8'h83;
         4'hC:    seg_o = 8'hC6;
         4'hD:    seg_o = 8'hA1;
         4'hE:    seg_o = 8'h86;
         default: seg_o = 8'h8E;
      endcase
   end
endmodule

// File: rtl/calc_display.sv
// Captures the calculator digit stream into a shadow frame, commits it on
// the return to ready, and scans the visible frame onto 7-segment displays.
module calc_display #(
   parameter int NUM_DIGITS  = calc_pkg::NUM_DIGITS,
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_DIV   = 256,
   parameter int BLANK_LZ    = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [1:0]            status,
   input  logic [3:0]            data,
   input  logic [3:0]            pos,
   output logic [NUM_DIGITS-1:0] an,
   output logic [7:0]            seg,
   output logic                  frame_valid,
   output logic                  err
);
   import calc_pkg::*;

   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int RW = $clog2(REFRESH_DIV);
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [NUM_DIGITS-1:0][3:0] shadow_q, visible_q;
   logic [NUM_DIGITS-1:0]      seen_q, lz_blank;
   logic [1:0]                 status_q;
   logic [IW-1:0]              scan_idx_q;
   logic [RW-1:0]              refresh_cnt_q;
   logic [BW-1:0]              blink_cnt_q;
   logic                       blink_q, err_q, frame_valid_q;
   logic [NUM_DIGITS-1:0]      an_q, an_d;
   logic [7:0]                 seg_q, seg_d, dec_seg;
   logic                       pos_ok, capture, commit, tick, zero_above;

   assign pos_ok  = {1'b0, pos} < 5'(NUM_DIGITS);
   assign capture = (status != ST_PRONTO) && pos_ok;
   assign commit  = (status == ST_PRONTO) && (status_q != ST_PRONTO);
   assign tick    = (refresh_cnt_q == RW'(REFRESH_DIV - 1));

   // Walk down from the top digit; a digit is blank while everything above it is zero.
   always_comb begin
      lz_blank   = '0;
      zero_above = 1'b1;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
         zero_above  = zero_above && (visible_q[k] == 4'd0);
         lz_blank[k] = zero_above && (BLANK_LZ != 0);
      end
   end

   hex7seg u_dec (
      .val_i (visible_q[scan_idx_q]),
      .seg_o (dec_seg)
   );

   always_comb begin
      an_d             = '1;
      an_d[scan_idx_q] = 1'b0;
      if (err_q)
         seg_d = (blink_q || (scan_idx_q != '0)) ? SEG_BLANK : SEG_E;
      else if (lz_blank[scan_idx_q])
         seg_d = SEG_BLANK;
      else
         seg_d = dec_seg;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         shadow_q      <= '0;
         visible_q     <= '0;
         seen_q        <= '0;
         status_q      <= ST_PRONTO;
         scan_idx_q    <= '0;
         refresh_cnt_q <= '0;
         blink_cnt_q   <= '0;
         blink_q       <= 1'b0;
         err_q         <= 1'b0;
         frame_valid_q <= 1'b0;
         an_q          <= '1;
         seg_q         <= SEG_BLANK;
      end else begin
         status_q      <= status;
         frame_valid_q <= commit && (&seen_q);
         if (status == ST_ERRO)
            err_q <= 1'b1;

         // Capture and commit are exclusive: capture needs status != ready.
         if (commit) begin
            seen_q <= '0;
            if (&seen_q)
               visible_q <= shadow_q;
         end else if (capture) begin
            shadow_q[pos[IW-1:0]] <= data;
            seen_q[pos[IW-1:0]]   <= 1'b1;
         end

         refresh_cnt_q <= tick ? '0 : refresh_cnt_q + 1'b1;
         if (tick) begin
            scan_idx_q <= (scan_idx_q == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
            if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
               blink_cnt_q <= '0;
               blink_q     <= ~blink_q;
            end else begin
               blink_cnt_q <= blink_cnt_q + 1'b1;
            end
         end

         an_q  <= an_d;
         seg_q <= seg_d;
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign frame_valid = frame_valid_q;
   assign err         = err_q;
endmodule

// File: tb/tb_calc_display.sv
// Directed bench for calc_display: capture/commit, scan decode, blanking, error blink.
module tb_calc_display;
   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] status;
   logic [3:0] data, pos;
   logic [7:0] an, seg, an_b, seg_b;
   logic       frame_valid, err, frame_valid_b, err_b;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   calc_display #(.NUM_DIGITS(8), .REFRESH_DIV(4), .BLINK_DIV(2), .BLANK_LZ(1)) dut (
      .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
      .an(an), .seg(seg), .frame_valid(frame_valid), .err(err)
   );

   // Second instance with an odd blink divisor so the blink phase drifts across visits of digit 0.
   calc_display #(.NUM_DIGITS(8), .REFRESH_DIV(4), .BLINK_DIV(3), .BLANK_LZ(1)) dut_b (
      .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
      .an(an_b), .seg(seg_b), .frame_valid(frame_valid_b), .err(err_b)
   );

   task automatic put(input logic [1:0] st, input logic [3:0] p, input logic [3:0] d);
      status = st; pos = p; data = d;
      @(negedge clock);
   endtask

   task automatic send_frame(input logic [1:0] st, input logic [7:0][3:0] fr);
      for (int i = 0; i < 8; i++) put(st, 4'(i), fr[i]);
   endtask

   // Waits for the scan to arrive at digit k and returns the segments shown there.
   task automatic visit(input int k, input bit b, output logic [7:0] s, output bit ok);
      logic [7:0] tgt, prev, cur;
      tgt  = ~(8'(1) << k);
      prev = b ? an_b : an;
      ok   = 1'b0;
      s    = 8'hxx;
      for (int i = 0; i < 80 && !ok; i++) begin
         @(negedge clock);
         cur = b ? an_b : an;
         if (cur == tgt && prev != tgt) begin
            ok = 1'b1;
            s  = b ? seg_b : seg;
         end
         prev = cur;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; status = 2'b10; pos = 4'd0; data = 4'd0;
      repeat (3) @(negedge clock);
      checks++; if (an !== 8'hFF) begin errors++; $display("FAIL reset_an got %h want ff", an); end
      checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h want ff", seg); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b want 0", frame_valid); end
      reset = 1'b0;
      @(negedge clock);
      checks++; if (an !== 8'hFE) begin errors++; $display("FAIL first_scan_an got %h want fe", an); end
      checks++; if (seg !== 8'hC0) begin errors++; $display("FAIL first_scan_seg got %h want c0", seg); end
   endtask

   task automatic test_frame;
      logic [7:0][7:0] e;
      logic [7:0] s;
      bit ok;
      send_frame(2'b01, {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd5});
      status = 2'b10;
      @(negedge clock);
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL frame_fv_pulse got %b want 1", frame_valid); end
      @(negedge clock);
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL frame_fv_single got %b want 0", frame_valid); end
      e = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'h92};
      for (int k = 0; k < 8; k++) begin
         visit(k, 1'b0, s, ok);
         checks++;
         if (!ok || s !== e[k]) begin errors++; $display("FAIL frame_pos%0d seg=%h found=%b want %h", k, s, ok, e[k]); end
      end
   endtask

   task automatic test_incomplete;
      logic [7:0][7:0] e;
      logic [7:0] s;
      bit ok;
      for (int i = 0; i < 6; i++) put(2'b01, 4'(i), 4'd8);
      status = 2'b10;
      for (int c = 0; c < 2; c++) begin
         @(negedge clock);
         checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL incomplete_fv cycle%0d got %b want 0", c, frame_valid); end
      end
      e = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'h92};
      for (int k = 0; k < 3; k++) begin
         visit(k, 1'b0, s, ok);
         checks++;
         if (!ok || s !== e[k]) begin errors++; $display("FAIL incomplete_keep_pos%0d seg=%h found=%b want %h", k, s, ok, e[k]); end
      end
      send_frame(2'b01, {8{4'd9}});
      status = 2'b10;
      @(negedge clock);
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL nines_fv got %b want 1", frame_valid); end
      for (int k = 0; k < 8; k++) begin
         visit(k, 1'b0, s, ok);
         checks++;
         if (!ok || s !== 8'h90) begin errors++; $display("FAIL nines_pos%0d seg=%h found=%b want 90", k, s, ok); end
      end
   endtask

   task automatic test_overwrite;
      logic [7:0][7:0] e;
      logic [7:0] s;
      bit ok;
      put(2'b01, 4'd0, 4'd6); put(2'b01, 4'd1, 4'd0); put(2'b01, 4'd2, 4'd3);
      put(2'b01, 4'd3, 4'd0); put(2'b01, 4'd4, 4'd0); put(2'b01, 4'd5, 4'd0);
      put(2'b01, 4'd6, 4'd0); put(2'b01, 4'd7, 4'd1);
      put(2'b01, 4'd9, 4'd7); put(2'b01, 4'd2, 4'd4);
      status = 2'b10;
      @(negedge clock);
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL overwrite_fv got %b want 1", frame_valid); end
      e = {8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h99, 8'hC0, 8'h82};
      for (int k = 0; k < 8; k++) begin
         visit(k, 1'b0, s, ok);
         checks++;
         if (!ok || s !== e[k]) begin errors++; $display("FAIL overwrite_pos%0d seg=%h found=%b want %h", k, s, ok, e[k]); end
      end
   endtask

   task automatic test_hex_reserved_status;
      logic [7:0][7:0] e;
      logic [7:0] s;
      bit ok;
      send_frame(2'b11, {4'h8, 4'h7, 4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA});
      status = 2'b10;
      @(negedge clock);
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL hex_fv got %b want 1", frame_valid); end
      e = {8'h80, 8'hF8, 8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88};
      for (int k = 0; k < 8; k++) begin
         visit(k, 1'b0, s, ok);
         checks++;
         if (!ok || s !== e[k]) begin errors++; $display("FAIL hex_pos%0d seg=%h found=%b want %h", k, s, ok, e[k]); end
      end
   endtask

   task automatic test_error;
      logic [7:0] s;
      bit ok;
      int n_e, n_blank, n_other;
      put(2'b01, 4'd0, 4'd1); put(2'b01, 4'd1, 4'd2); put(2'b00, 4'd2, 4'd3);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", err); end
      for (int i = 3; i < 8; i++) put(2'b01, 4'(i), 4'(i + 1));
      status = 2'b10;
      @(negedge clock);
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL err_capture_fv got %b want 1", frame_valid); end
      for (int v = 0; v < 3; v++) begin
         visit(0, 1'b0, s, ok);
         checks++;
         if (!ok || s !== 8'h86) begin errors++; $display("FAIL err_pos0_visit%0d seg=%h found=%b want 86", v, s, ok); end
      end
      visit(3, 1'b0, s, ok);
      checks++; if (!ok || s !== 8'hFF) begin errors++; $display("FAIL err_pos3 seg=%h found=%b want ff", s, ok); end
      n_e = 0; n_blank = 0; n_other = 0;
      for (int v = 0; v < 3; v++) begin
         visit(0, 1'b1, s, ok);
         if (!ok) n_other++;
         else if (s === 8'h86) n_e++;
         else if (s === 8'hFF) n_blank++;
         else n_other++;
      end
      checks++;
      if (n_e != 2 || n_blank != 1 || n_other != 0) begin
         errors++; $display("FAIL err_blink lit=%0d blank=%0d other=%0d want 2/1/0", n_e, n_blank, n_other);
      end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
      reset = 1'b1;
      @(negedge clock);
      checks++; if (err !== 1'b0 || err_b !== 1'b0) begin errors++; $display("FAIL err_reset got %b/%b want 0/0", err, err_b); end
      checks++; if (an !== 8'hFF) begin errors++; $display("FAIL err_reset_an got %h want ff", an); end
      reset = 1'b0;
   endtask

   task automatic test_reset_midframe;
      logic [7:0] s;
      bit ok;
      for (int i = 0; i < 4; i++) put(2'b01, 4'(i), 4'd2);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      for (int i = 4; i < 8; i++) put(2'b01, 4'(i), 4'd3);
      status = 2'b10;
      for (int c = 0; c < 2; c++) begin
         @(negedge clock);
         checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL midreset_fv cycle%0d got %b want 0", c, frame_valid); end
      end
      visit(0, 1'b0, s, ok);
      checks++; if (!ok || s !== 8'hC0) begin errors++; $display("FAIL midreset_pos0 seg=%h found=%b want c0", s, ok); end
      visit(1, 1'b0, s, ok);
      checks++; if (!ok || s !== 8'hFF) begin errors++; $display("FAIL midreset_pos1 seg=%h found=%b want ff", s, ok); end
      send_frame(2'b01, {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3});
      status = 2'b10;
      @(negedge clock);
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL midreset_full_fv got %b want 1", frame_valid); end
      visit(0, 1'b0, s, ok);
      checks++; if (!ok || s !== 8'hB0) begin errors++; $display("FAIL midreset_full_pos0 seg=%h found=%b want b0", s, ok); end
      visit(7, 1'b0, s, ok);
      checks++; if (!ok || s !== 8'hFF) begin errors++; $display("FAIL midreset_full_pos7 seg=%h found=%b want ff", s, ok); end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_incomplete();
      test_overwrite();
      test_hex_reserved_status();
      test_error();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/calc_display.md
Name: calc_display

Overview:
- Receiving end of the calculator's digit stream (status, data, pos).
- Captures the eight BCD digits sent one per cycle while the calculator is busy. Commits the frame to a visible buffer when status returns to ready.
- Time-multiplexes the visible buffer onto eight common-anode 7-segment displays.
- Sits between calc and the board pins and owns all display refresh timing.

Parameters:
- NUM_DIGITS, 8, number of display positions captured and scanned.
- REFRESH_DIV, 50000, clock cycles each digit stays lit (≥2).
- BLINK_DIV, 256, refresh ticks per half-period of the error blink.
- BLANK_LZ, 1, 1 = blank leading zeros above the most significant non-zero digit.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- status  in  2  calculator status: 00 erro, 01 ocupado, 10 pronto, 11 reserved (treated as 01)
- data  in  4  digit value for position pos, valid in the same cycle as pos
- pos  in  4  digit position 0..7; values >7 ignored
- an  out  8  anode enables, active-low, one-hot-low while scanning
- seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
- frame_valid  out  1  one-cycle pulse when a complete frame is committed
- err  out  1  sticky error flag

Behaviour:
- Single clock; all state is updated on posedge clock. Reset is synchronous, active-high, and overrides everything.
- Reset values:
  - an=8'hFF, seg=8'hFF
  - visible[*]=0, shadow[*]=0, seen=0
  - scan_idx=0, refresh_cnt=0, blink_cnt=0, blink=0
  - frame_valid=0, err=0, status_q=10
- Capture:
  - Each cycle with status!=10 and pos<NUM_DIGITS: shadow[pos]<=data and seen[pos]<=1.
  - A repeated pos overwrites the earlier value; the last write wins.
- Commit:
  - Trigger is an edge into ready: status==10 with registered status_q!=10.
  - If &seen: visible<=shadow, frame_valid pulses high for exactly 1 cycle (cycle after the edge), seen<=0.
  - If any seen bit is clear: the frame is discarded, seen<=0, visible is unchanged, and there is no pulse.
- Capture and commit in the same cycle cannot occur, because capture requires status!=10.
- Error:
  - status==00 on any cycle sets err<=1. err stays set until reset.
  - Digits are still captured during error.
  - While err=1, the display overrides visible:
    - Position 0 shows 'E' (seg=8'b1000_0110).
    - All other positions are blank (8'hFF).
    - The whole display blinks: it is blank when blink=1.
    - blink toggles every BLINK_DIV refresh ticks.
- Scan:
  - refresh_cnt counts 0..REFRESH_DIV-1 and wraps.
  - On the wrap (refresh tick), scan_idx<=scan_idx+1 modulo NUM_DIGITS.
  - an and seg are registered outputs, updated on the cycle following the scan_idx change, which gives 1 cycle of latency.
  - an[scan_idx]=0 and all other bits are 1.
- Decode:
  - Values 0-9 use standard patterns; 10-15 show hex A,b,C,d,E,F.
  - dp is always off.
- Blanking (BLANK_LZ=1):
  - Position k>0 is blanked (seg=8'hFF, anode still driven) if visible[k] and all higher positions are 0.
  - Position 0 is never blanked.
- Reset mid-frame: everything returns to reset values and partial shadow contents are lost. The first commit after reset requires a full 8-digit frame.

Decomposition:
- Package calc_pkg holds:
  - typedef enum logic [1:0] status_t {ST_ERRO=2'b00, ST_OCUPADO=2'b01, ST_PRONTO=2'b10}
  - localparam NUM_DIGITS=8
  - SEG_BLANK=8'hFF and SEG_E
- One combinational sub-module, hex7seg: 4-bit value → 8-bit active-low segment pattern. Instantiated once, on the scan-selected digit.

Test Plan (REFRESH_DIV=4, BLINK_DIV=2):
- Reset held 3 cycles → an=8'hFF, seg=8'hFF, err=0, frame_valid=0. After release, the first refresh tick scans an=8'hFE.
- Frame: status=01 with pos 0..7 carrying data 5,2,1,0,0,0,0,0, then status=10 → frame_valid high exactly 1 cycle. Scanning then shows 5,2,1 on positions 0-2 and positions 3-7 blank.
- Incomplete frame: status=01 with pos 0..5 only, then status=10 → no frame_valid and the previous display is unchanged. The next full frame (all 9s) commits 9 on all eight positions.
- Out-of-range and overwrite: pos=9 data=7 is ignored. pos=2 written as 3 then 4 → committed digit 2 = 4.
- Error: status=00 for 1 cycle mid-frame → err=1 permanently. Position 0 shows SEG_E, others are blank, and the display alternates on/off every 2 refresh ticks. Reset clears err.
- Reset mid-frame: assert reset after pos 0..3 are captured, then send pos 4..7 and status=10 → no commit. A full frame is then required for frame_valid.
